// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : matrix_pkg                                             |
// | Description : Shared types and constants for the matrix host        |
// |               sequencer: FSM state encoding, pulse phase encoding,   |
// |               default timing constants and element counts.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package matrix_pkg;

  // Default timing of the calculator enter strobe and finish wait
  localparam int c_hold_cyc_def = 2;
  localparam int c_gap_cyc_def  = 2;
  localparam int c_timeout_def  = 255;

  // 4 bytes of matrix A followed by 4 bytes of matrix B; 4 result words
  localparam int c_n_operands = 8;
  localparam int c_n_results  = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LD_SETUP = 4'd1,
    S_LD_PULSE = 4'd2,
    S_LD_GAP   = 4'd3,
    S_WAIT_FIN = 4'd4,
    S_RD_CAP   = 4'd5,
    S_RD_PULSE = 4'd6,
    S_RD_GAP   = 4'd7,
    S_DONE     = 4'd8,
    S_FAIL     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HOLD = 2'd1,
    PH_GAP  = 2'd2
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/enter_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : enter_pulse_gen                                        |
// | Description : One enter strobe per trigger: HOLD_CYC cycles high,    |
// |               then GAP_CYC cycles low. Flags the last high cycle and |
// |               the last low cycle so the sequencer can step states.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module enter_pulse_gen
  import matrix_pkg::*;
#(
  parameter int HOLD_CYC = c_hold_cyc_def,
  parameter int GAP_CYC  = c_gap_cyc_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trig,
  input  logic i_abort,
  output logic o_enter,
  output logic o_hold_end,
  output logic o_done
);

  localparam int CW = $clog2((HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC) + 1);

  phase_t          r_phase;
  logic [CW-1:0]   r_cnt;
  logic            r_enter;
  logic            w_hold_last;
  logic            w_gap_last;

  assign w_hold_last = (r_phase == PH_HOLD) && (r_cnt == CW'(HOLD_CYC - 1));
  assign w_gap_last  = (r_phase == PH_GAP)  && (r_cnt == CW'(GAP_CYC - 1));

  assign o_enter    = r_enter;
  assign o_hold_end = w_hold_last;
  assign o_done     = w_gap_last;

  // Phase sequencer: idle -> hold (strobe high) -> gap (strobe low) -> idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_enter <= 1'b0;
    end else if (i_abort) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_enter <= 1'b0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (i_trig) begin
            r_phase <= PH_HOLD;
            r_cnt   <= '0;
            r_enter <= 1'b1;
          end
        end
        PH_HOLD: begin
          if (w_hold_last) begin
            r_phase <= PH_GAP;
            r_cnt   <= '0;
            r_enter <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PH_GAP: begin
          if (w_gap_last) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_phase <= PH_IDLE;
          r_cnt   <= '0;
          r_enter <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_host_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : matrix_host_seq                                        |
// | Description : Host-side sequencer for a matrix calculator. Streams   |
// |               8 operand bytes with enter strobes, waits for finish,  |
// |               then collects 4 indexed result words into a buffer.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module matrix_host_seq
  import matrix_pkg::*;
#(
  parameter int HOLD_CYC = c_hold_cyc_def,
  parameter int GAP_CYC  = c_gap_cyc_def,
  parameter int TIMEOUT  = c_timeout_def
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op_in,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [4:0] rd_data,
  output logic [7:0] calc_data_in,
  output logic       calc_enter,
  output logic       calc_sw,
  output logic [1:0] calc_op,
  input  logic [4:0] calc_data_out,
  input  logic       calc_finish,
  input  logic       calc_error,
  input  logic [3:0] calc_index,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [7:0]      r_opnd   [c_n_operands];
  logic [4:0]      r_result [c_n_results];
  logic [3:0]      r_k;
  logic [2:0]      r_r;
  logic [WCW-1:0]  r_wait;
  logic [7:0]      r_calc_data_in;
  logic            r_calc_sw;
  logic [1:0]      r_calc_op;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_active;
  logic            w_err_abort;
  logic            w_idx_match;
  logic            w_trig;
  logic            w_hold_end;
  logic            w_pulse_done;
  logic [3:0]      w_k_next;
  logic [7:0]      w_first_byte;

  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
  assign w_err_abort = w_active && calc_error;
  assign w_idx_match = (calc_index == {1'b0, r_r});
  assign w_k_next    = r_k + 4'd1;

  // A write to byte 0 in the start cycle must reach the calculator
  assign w_first_byte = (wr_en && (wr_addr == 3'd0)) ? wr_data : r_opnd[0];

  // Launch a strobe from setup, or after a capture that still needs more words
  assign w_trig = !w_err_abort &&
                  ((r_state == S_LD_SETUP) ||
                   ((r_state == S_RD_CAP) && w_idx_match && (r_r != 3'(c_n_results - 1))));

  assign rd_data      = r_result[rd_addr];
  assign calc_data_in = r_calc_data_in;
  assign calc_sw      = r_calc_sw;
  assign calc_op      = r_calc_op;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

  enter_pulse_gen #(
    .HOLD_CYC (HOLD_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_pulse (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_trig     (w_trig),
    .i_abort    (w_err_abort),
    .o_enter    (calc_enter),
    .o_hold_end (w_hold_end),
    .o_done     (w_pulse_done)
  );

  // Operand buffer: host writes accepted only while no transaction runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_n_operands; i++) r_opnd[i] <= '0;
    end else if (wr_en && !r_busy) begin
      r_opnd[wr_addr] <= wr_data;
    end
  end

  // Result buffer: written only by a capture whose index matches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_n_results; i++) r_result[i] <= '0;
    end else if ((r_state == S_RD_CAP) && !w_err_abort && w_idx_match) begin
      r_result[r_r[1:0]] <= calc_data_out;
    end
  end

  // Transaction sequencer: load operands, wait for finish, collect results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_calc_data_in <= '0;
      r_calc_sw      <= 1'b0;
      r_calc_op      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_k            <= '0;
      r_r            <= '0;
      r_wait         <= '0;
    end else if (w_err_abort) begin
      r_state <= S_FAIL;
      r_err   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_calc_op      <= op_in;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_k            <= '0;
            r_r            <= '0;
            r_wait         <= '0;
            r_busy         <= 1'b1;
            r_calc_data_in <= w_first_byte;
            r_calc_sw      <= 1'b0;
            r_state        <= S_LD_SETUP;
          end
        end
        S_LD_SETUP: r_state <= S_LD_PULSE;
        S_LD_PULSE: if (w_hold_end) r_state <= S_LD_GAP;
        S_LD_GAP: begin
          if (w_pulse_done) begin
            r_k <= w_k_next;
            if (w_k_next == 4'(c_n_operands)) begin
              r_wait  <= '0;
              r_state <= S_WAIT_FIN;
            end else begin
              r_calc_data_in <= r_opnd[w_k_next[2:0]];
              r_calc_sw      <= w_k_next[2];
              r_state        <= S_LD_SETUP;
            end
          end
        end
        S_WAIT_FIN: begin
          if (calc_finish) begin
            r_r     <= '0;
            r_state <= S_RD_CAP;
          end else if (r_wait == WCW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAIL;
          end else begin
            r_wait <= r_wait + WCW'(1);
          end
        end
        S_RD_CAP: begin
          if (w_idx_match) begin
            r_r <= r_r + 3'd1;
            if (r_r == 3'(c_n_results - 1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_PULSE;
            end
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAIL;
          end
        end
        S_RD_PULSE: if (w_hold_end) r_state <= S_RD_GAP;
        S_RD_GAP:   if (w_pulse_done) r_state <= S_RD_CAP;
        S_DONE:     r_state <= S_IDLE;
        S_FAIL:     r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
